// File: rtl/key_move_encoder.sv
// Direction push-button front end: sync, per-key debounce, priority pick, game gating, hold-to-repeat.
// Optional feature macro: KEY_AUTO_REPEAT_EN (defined = hold-to-repeat; undefined = one pulse per press).
module key_move_encoder #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 7500000,
    parameter int CNT_W           = 25
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic [3:0] key,
    input  logic       enable,
    output logic [3:0] move_pulse,
    output logic [3:0] key_held,
    output logic       repeating
);

    if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W) ||
        REPEAT_DELAY < 1 || 64'(REPEAT_DELAY) >= (64'd1 << CNT_W) ||
        REPEAT_RATE < 1 || 64'(REPEAT_RATE) >= (64'd1 << CNT_W)) begin : g_param_check
        $error("key_move_encoder: cycle parameters must be in [1, 2^CNT_W)");
    end

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    function automatic logic [1:0] prio(input logic [3:0] k);
        logic [1:0] s;
        s = 2'd0;
        if (k[3])      s = 2'd3;
        else if (k[2]) s = 2'd2;
        else if (k[1]) s = 2'd1;
        return s;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

    // Stage p0/p1: two-flop synchroniser
    logic [3:0] key_p0, key_p1;

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            key_p0 <= '0;
            key_p1 <= '0;
        end else begin
            key_p0 <= key;
            key_p1 <= key_p0;
        end
    end

    // Debounce: a level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    logic [CNT_W-1:0] db_cnt [4];

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
            key_held <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (key_p1[i] == key_held[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i]   <= '0;
                    key_held[i] <= ~key_held[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef KEY_AUTO_REPEAT_EN
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT_ALL} state_t;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);
    logic [CNT_W-1:0] rcnt, rcnt_nx;
`else
    typedef enum logic [1:0] {IDLE, HOLD, WAIT_ALL} state_t;
`endif

    state_t     state, state_nx;
    logic [1:0] sel, sel_nx;
    logic       pend, pend_nx;
    logic [3:0] pulse_nx;
    logic       stop;

    // A release or loss of enable always beats a pending or terminal-count pulse.
    assign stop = !key_held[sel] || !enable;

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        pend_nx  = pend;
        pulse_nx = '0;
`ifdef KEY_AUTO_REPEAT_EN
        rcnt_nx  = rcnt;
`endif
        case (state)
            IDLE: begin
                if (enable && key_held != 4'b0000) begin
                    sel_nx   = prio(key_held);
                    pend_nx  = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (stop) begin
                    pend_nx  = 1'b0;
                    state_nx = WAIT_ALL;
                end else if (pend) begin
                    pulse_nx = onehot(sel);
                    pend_nx  = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
                    rcnt_nx  = '0;
                end else if (rcnt == RD_LAST) begin
                    pulse_nx = onehot(sel);
                    rcnt_nx  = '0;
                    state_nx = REPEAT;
                end else begin
                    rcnt_nx  = rcnt + CNT_W'(1);
`endif
                end
            end
`ifdef KEY_AUTO_REPEAT_EN
            REPEAT: begin
                if (stop) begin
                    state_nx = WAIT_ALL;
                end else if (rcnt == RR_LAST) begin
                    pulse_nx = onehot(sel);
                    rcnt_nx  = '0;
                end else begin
                    rcnt_nx  = rcnt + CNT_W'(1);
                end
            end
`endif
            WAIT_ALL: begin
                if (key_held == 4'b0000) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage p2: registered FSM state and move pulse
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state      <= IDLE;
            pend       <= 1'b0;
            move_pulse <= '0;
`ifdef KEY_AUTO_REPEAT_EN
            rcnt       <= '0;
`endif
        end else begin
            state      <= state_nx;
            pend       <= pend_nx;
            move_pulse <= pulse_nx;
`ifdef KEY_AUTO_REPEAT_EN
            rcnt       <= rcnt_nx;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        sel <= sel_nx;
    end

`ifdef KEY_AUTO_REPEAT_EN
    assign repeating = (state == REPEAT);
`else
    assign repeating = 1'b0;
`endif

endmodule
